sum_display: RTL and testbench
==============================

SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 The block SHALL have parameter REFRESH_BITS, default 16, the width of the free-running digit-refresh counter.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all flops SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port sum_valid, input, 1, asserted when sum/carry from the upstream 4-bit adder are valid.
REQ-005 The block SHALL have port sum, input, 4, the adder sum output.
REQ-006 The block SHALL have port carry, input, 1, the adder carry-out, with weight 16.
REQ-007 The block SHALL have port ready, output, 1, high when a new sum can be accepted.
REQ-008 The block SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have port an, output, 4, active-low digit anodes.
REQ-010 The block SHALL have port overflow_led, output, 1, the carry bit of the currently displayed value.

Function
REQ-011 A capture SHALL occur at a rising edge where sum_valid=1 and ready=1; it latches value = {carry,sum} (0..31) into a 5-bit remainder register, clears the tens register, and enters CONV.
REQ-012 The FSM SHALL have two states: IDLE (ready=1, accepts) and CONV (ready=0, sum_valid ignored).
REQ-013 In CONV, at each edge where remainder >= 10, the block SHALL subtract 10 from the remainder and increment tens (2 bits).
REQ-014 In CONV, at the edge where remainder < 10, the block SHALL commit ones=remainder[3:0], disp_tens=tens and overflow_led=captured carry, and return to IDLE.
REQ-015 Latency: for a capture at edge E with T = value/10, the commit SHALL occur at edge E+T+1, and ready SHALL be high from edge E+T+1 (4 cycles maximum, for value 31).
REQ-016 ready SHALL be a registered output equal to (next_state==IDLE).
REQ-017 The displayed digits SHALL hold their previous values until commit; no partial result SHALL ever be visible.
REQ-018 A free-running REFRESH_BITS-wide counter SHALL wrap naturally; its MSB SHALL select the digit.
REQ-019 MSB=0 SHALL drive an=4'b1110 and seg=decode(ones).
REQ-020 MSB=1 SHALL drive an=4'b1101 and seg=decode(disp_tens).
REQ-021 When disp_tens=0, the tens slot SHALL be blanked: an=4'b1111.
REQ-022 an[3:2] SHALL always be 1.
REQ-023 seg/an SHALL be registered, one cycle behind the counter MSB.
REQ-024 The segment encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 SHALL give 1111111.
REQ-025 When sum_valid is held high continuously, exactly one capture SHALL occur per IDLE visit; values presented during CONV SHALL be dropped.

Reset
REQ-026 While rst_n=0, the block SHALL hold: state=IDLE, ready=0, remainder=0, tens=0, ones=0, disp_tens=0, refresh counter=0, overflow_led=0, an=4'b1110, seg=7'b1000000.
REQ-027 ready SHALL rise at the first clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-CONV SHALL abort the conversion immediately, with no commit.

Structure
REQ-029 A shared package sum_display_pkg SHALL hold the state encoding, the anode codes (AN_ONES, AN_TENS, AN_OFF), and the segment constants SEG_0..SEG_9 and SEG_BLANK.
REQ-030 Sub-module seg7_decoder SHALL be a combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed digit.

Verification
REQ-031 The bench SHALL check: reset pulsed during CONV of value 31 -> outputs match REQ-026 asynchronously; ready=1 one edge after release.
REQ-032 The bench SHALL check: sum=4'hF, carry=1 -> ready low 4 cycles; tens slot seg=0110000, ones slot seg=1111001; overflow_led=1.
REQ-033 The bench SHALL check: sum=9, carry=0 -> commit at next edge (ready low 1 cycle); tens slot an=1111; ones seg=0010000.
REQ-034 The bench SHALL check: sum=4, carry=1 (20) -> tens seg=0100100, ones seg=1000000, overflow_led=1, after 3 cycles.
REQ-035 The bench SHALL check: sum_valid held high while sum steps 1,2,3 every cycle -> only the values sampled when ready=1 are displayed.
REQ-036 The bench SHALL check: REFRESH_BITS=4 -> an alternates between 1110 and 1101 every 8 cycles, lagging the counter by 1 cycle.

Source files
------------

// File: rtl/sum_display_pkg.sv
// rtl/sum_display_pkg.sv - shared state encoding, anode codes and segment constants
package sum_display_pkg;

   // Conversion FSM states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_t;

   // Active-low anode codes; an[3:2] are never driven low
   localparam logic [3:0] AN_ONES = 4'b1110;
   localparam logic [3:0] AN_TENS = 4'b1101;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Decimal base used by the repeated-subtraction converter
   localparam logic [4:0] DEC_BASE = 5'd10;

endpackage

// File: rtl/sum_display_seg7_decoder.sv
// rtl/sum_display_seg7_decoder.sv - combinational 4-bit to active-low 7-segment decoder
module seg7_decoder
   import sum_display_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   // Map a BCD digit to its segment pattern; non-decimal codes go dark
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sum_display.sv
// rtl/sum_display.sv - captures a 5-bit adder result, converts to decimal, multiplexes two 7-segment digits
module sum_display
   import sum_display_pkg::*;
#(
   parameter int REFRESH_BITS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sum_valid,
   input  logic [3:0] sum,
   input  logic       carry,
   output logic       ready,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       overflow_led
);

   state_t                  r_state;
   logic                    r_ready;
   logic [4:0]              r_rem;
   logic [1:0]              r_tens;
   logic                    r_carry;
   logic [3:0]              r_ones;
   logic [1:0]              r_disp_tens;
   logic                    r_ovf;
   logic [REFRESH_BITS-1:0] r_refresh;
   logic [6:0]              r_seg;
   logic [3:0]              r_an;

   logic                    w_msb;
   logic [3:0]              w_digit;
   logic [6:0]              w_seg;

   assign ready        = r_ready;
   assign seg          = r_seg;
   assign an           = r_an;
   assign overflow_led = r_ovf;

   // Capture, convert by repeated subtraction of ten, then commit both digits at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b0;
         r_rem       <= '0;
         r_tens      <= '0;
         r_carry     <= 1'b0;
         r_ones      <= '0;
         r_disp_tens <= '0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (sum_valid && r_ready) begin
                  r_rem   <= {carry, sum};
                  r_tens  <= '0;
                  r_carry <= carry;
                  r_state <= ST_CONV;
                  r_ready <= 1'b0;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_CONV: begin
               if (r_rem >= DEC_BASE) begin
                  r_rem   <= r_rem - DEC_BASE;
                  r_tens  <= r_tens + 2'd1;
                  r_ready <= 1'b0;
               end else begin
                  r_ones      <= r_rem[3:0];
                  r_disp_tens <= r_tens;
                  r_ovf       <= r_carry;
                  r_state     <= ST_IDLE;
                  r_ready     <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Free-running refresh counter; its MSB picks which digit is lit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_refresh <= '0;
      end else begin
         r_refresh <= r_refresh + REFRESH_BITS'(1);
      end
   end

   assign w_msb   = r_refresh[REFRESH_BITS-1];
   assign w_digit = w_msb ? {2'b00, r_disp_tens} : r_ones;

   seg7_decoder u_decoder (
      .i_digit (w_digit),
      .o_seg   (w_seg)
   );

   // Register the muxed digit drive; a zero tens digit keeps its anode dark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= AN_ONES;
         r_seg <= SEG_0;
      end else begin
         r_seg <= w_seg;
         if (!w_msb) begin
            r_an <= AN_ONES;
         end else if (r_disp_tens == 2'd0) begin
            r_an <= AN_OFF;
         end else begin
            r_an <= AN_TENS;
         end
      end
   end

endmodule

// File: tb/tb_sum_display.sv
// tb/tb_sum_display.sv - randomized self-checking bench for sum_display against a behavioural model
module tb_sum_display;

   localparam int RB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sum_valid;
   logic [3:0] sum;
   logic       carry;
   logic       ready;
   logic [6:0] seg;
   logic [3:0] an;
   logic       overflow_led;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int   n;
   logic m_ready;
   logic m_pending;
   int   m_commit_edge;
   int   m_val;
   int   m_ones;
   int   m_tens;
   logic m_ovf;

   sum_display #(.REFRESH_BITS(RB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sum_valid    (sum_valid),
      .sum          (sum),
      .carry        (carry),
      .ready        (ready),
      .seg          (seg),
      .an           (an),
      .overflow_led (overflow_led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic model_reset();
      n = 0; m_ready = 1'b0; m_pending = 1'b0; m_commit_edge = 0; m_val = 0;
      m_ones = 0; m_tens = 0; m_ovf = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      check({tag, "_an"}, 32'(an), 32'(4'b1110));
      check({tag, "_seg"}, 32'(seg), 32'(7'b1000000));
      check({tag, "_ovf"}, 32'(overflow_led), 32'd0);
   endtask

   // One clock edge: advance the model and compare every output
   task automatic step();
      int         p_ones, p_tens, v;
      logic       cap, msb;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      p_ones = m_ones;
      p_tens = m_tens;
      v      = 16 * int'(carry) + int'(sum);
      cap    = sum_valid && m_ready;
      msb    = (n % (1 << RB)) >= (1 << (RB - 1));
      @(posedge clk);
      #1;
      n++;
      if (m_pending && n == m_commit_edge) begin
         m_ones    = m_val % 10;
         m_tens    = m_val / 10;
         m_ovf     = (m_val >= 16);
         m_pending = 1'b0;
      end
      if (cap) begin
         m_pending     = 1'b1;
         m_val         = v;
         m_commit_edge = n + v / 10 + 1;
      end
      m_ready = !m_pending;
      if (!msb) begin
         e_an = 4'b1110;  e_seg = ref_seg(p_ones);
      end else begin
         e_an = (p_tens == 0) ? 4'b1111 : 4'b1101;  e_seg = ref_seg(p_tens);
      end
      check($sformatf("ready@%0d", n), 32'(ready), 32'(m_ready));
      check($sformatf("ovf@%0d", n), 32'(overflow_led), 32'(m_ovf));
      check($sformatf("an@%0d", n), 32'(an), 32'(e_an));
      check($sformatf("seg@%0d", n), 32'(seg), 32'(e_seg));
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 10 && !m_ready; k++) step();
   endtask

   // Present one value, then measure how long ready stays low
   task automatic do_capture(input string tag, input int v);
      int lo;
      wait_idle();
      sum_valid = 1'b1;
      sum       = 4'(v);
      carry     = (v >= 16);
      step();
      sum_valid = 1'b0;
      lo = (ready == 1'b0) ? 1 : 0;
      for (int k = 0; k < 10 && ready == 1'b0; k++) begin
         step();
         if (ready == 1'b0) lo++;
      end
      check({tag, "_ready_low"}, 32'(lo), 32'(v / 10 + 1));
   endtask

   // Idle for a full refresh period and check what each digit slot shows
   task automatic check_slots(input string tag, input logic [6:0] ones_seg, input logic [6:0] tens_seg,
                              input logic tens_shown, input logic ovf);
      logic seen_o, seen_t;
      seen_o = 1'b0;
      seen_t = 1'b0;
      sum_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (an == 4'b1110 && !seen_o) begin
            check({tag, "_ones_seg"}, 32'(seg), 32'(ones_seg));
            seen_o = 1'b1;
         end
         if (an == 4'b1101 && !seen_t) begin
            check({tag, "_tens_seg"}, 32'(seg), 32'(tens_seg));
            seen_t = 1'b1;
         end
      end
      check({tag, "_ones_seen"}, 32'(seen_o), 32'd1);
      check({tag, "_tens_seen"}, 32'(seen_t), 32'(tens_shown));
      check({tag, "_ovf"}, 32'(overflow_led), 32'(ovf));
   endtask

   initial begin
      rst_n     = 1'b0;
      sum_valid = 1'b0;
      sum       = 4'd0;
      carry     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      #3;
      rst_n = 1'b1;
      step();
      check("ready_after_por", 32'(ready), 32'd1);

      // 31: three subtractions, ready low four cycles
      do_capture("v31", 31);
      check_slots("v31", 7'b1111001, 7'b0110000, 1'b1, 1'b1);

      // 9: commits at the next edge, tens slot blanked
      do_capture("v9", 9);
      check_slots("v9", 7'b0010000, 7'b1000000, 1'b0, 1'b0);

      // 20: tens 2, ones 0
      do_capture("v20", 20);
      check_slots("v20", 7'b1000000, 7'b0100100, 1'b1, 1'b1);

      // Reset in the middle of converting 31: no commit, immediate reset values
      wait_idle();
      sum_valid = 1'b1; sum = 4'hF; carry = 1'b1;
      step();
      sum_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midconv");
      @(posedge clk);
      #1;
      check_reset_outputs("midconv_hold");
      #3;
      rst_n = 1'b1;
      step();
      check("ready_after_midconv", 32'(ready), 32'd1);
      check_slots("after_abort", 7'b1000000, 7'b1000000, 1'b0, 1'b0);

      // sum_valid held high with sum stepping every cycle
      sum_valid = 1'b1;
      carry     = 1'b0;
      for (int k = 0; k < 15; k++) begin
         sum = 4'(k + 1);
         step();
      end
      sum_valid = 1'b0;
      wait_idle();
      check_slots("stream", ref_seg(m_ones), ref_seg(m_tens), m_tens != 0, m_ovf);

      // Refresh period: with tens shown, an alternates every half counter period
      do_capture("v13", 13);
      begin
         logic [3:0] prev;
         int run, trans;
         prev  = an;
         run   = 0;
         trans = 0;
         for (int k = 0; k < 40; k++) begin
            step();
            if (an == prev) begin
               run++;
            end else begin
               if (trans > 0) check("an_period", 32'(run), 32'(1 << (RB - 1)));
               trans++;
               run  = 1;
               prev = an;
            end
         end
         check("an_transitions_seen", 32'(trans >= 4), 32'd1);
      end

      // Randomized inputs every cycle
      for (int k = 0; k < 400; k++) begin
         sum_valid = 1'($urandom_range(0, 1));
         sum       = 4'($urandom);
         carry     = 1'($urandom);
         step();
      end
      sum_valid = 1'b0;
      wait_idle();
      for (int k = 0; k < 8; k++) do_capture($sformatf("rnd%0d", k), int'($urandom_range(0, 31)));
      check_slots("rnd_final", ref_seg(m_ones), ref_seg(m_tens), m_tens != 0, m_ovf);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
